// File: rtl/fir_mac_ctrl_if.sv
// Handshake bundle between the FIR sequencer, its input/output FIFOs and the shared MAC.
// The sequencer takes the master side; the FIFO/MAC environment takes the slave side.
interface fir_mac_ctrl_if #(
  parameter int DATA_SIZE = 32,
  parameter int NUM_TAPS  = 32
);
  localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  logic                        in_empty;
  logic signed [DATA_SIZE-1:0] in_dout;
  logic                        in_rd_en;
  logic                        mac_valid;
  logic                        mac_clear;
  logic signed [DATA_SIZE-1:0] mac_x;
  logic        [TAP_W-1:0]     mac_tap;
  logic signed [DATA_SIZE-1:0] mac_acc;
  logic                        out_full;
  logic                        out_wr_en;
  logic signed [DATA_SIZE-1:0] out_din;

  modport master (
    input  in_empty, in_dout, mac_acc, out_full,
    output in_rd_en, mac_valid, mac_clear, mac_x, mac_tap, out_wr_en, out_din
  );

  modport slave (
    output in_empty, in_dout, mac_acc, out_full,
    input  in_rd_en, mac_valid, mac_clear, mac_x, mac_tap, out_wr_en, out_din
  );
endinterface

// File: rtl/fir_mac_ctrl.sv
// FIR sequencer: loads DECIMATION samples into the tap history, streams NUM_TAPS
// (sample, tap) pairs to the external MAC, waits out its latency and pushes the sum.
module fir_mac_ctrl #(
  parameter int DATA_SIZE   = 32,
  parameter int NUM_TAPS    = 32,
  parameter int DECIMATION  = 1,
  parameter int MAC_LATENCY = 1
) (
  input  logic          clock,
  input  logic          reset,
  fir_mac_ctrl_if.master bus
);
  localparam int TAP_W  = (NUM_TAPS > 1)    ? $clog2(NUM_TAPS)    : 1;
  localparam int DEC_W  = (DECIMATION > 1)  ? $clog2(DECIMATION)  : 1;
  localparam int WAIT_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

  localparam logic [TAP_W-1:0]  LAST_TAP  = TAP_W'(NUM_TAPS - 1);
  localparam logic [DEC_W-1:0]  LAST_DEC  = DEC_W'(DECIMATION - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAC_LATENCY - 1);

  typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_WAIT, S_WRITE} state_t;

  state_t                      state, state_n;
  logic signed [DATA_SIZE-1:0] hist [NUM_TAPS];
  logic        [TAP_W-1:0]     tap_cnt;
  logic        [DEC_W-1:0]     dec_cnt;
  logic        [WAIT_W-1:0]    wait_cnt;
  logic                        pop;
  logic                        push;
  logic                        mac_valid_q;
  logic                        mac_clear_q;
  logic signed [DATA_SIZE-1:0] mac_x_q;
  logic signed [DATA_SIZE-1:0] result_q;

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    push    = 1'b0;
    case (state)
      S_LOAD: begin
        pop = !bus.in_empty;
        if (!bus.in_empty && (dec_cnt == LAST_DEC)) state_n = S_ISSUE;
      end
      S_ISSUE: begin
        if (tap_cnt == LAST_TAP) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == LAST_WAIT) state_n = S_WRITE;
      end
      S_WRITE: begin
        push = !bus.out_full;
        if (!bus.out_full) state_n = S_LOAD;
      end
      default: state_n = S_LOAD;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_LOAD;
      tap_cnt     <= '0;
      dec_cnt     <= '0;
      wait_cnt    <= '0;
      mac_valid_q <= 1'b0;
      mac_clear_q <= 1'b0;
      mac_x_q     <= '0;
      result_q    <= '0;
      for (int k = 0; k < NUM_TAPS; k++) hist[k] <= '0;
    end else begin
      state <= state_n;
      if (pop) begin
        hist[0] <= bus.in_dout;
        for (int k = 1; k < NUM_TAPS; k++) hist[k] <= hist[k-1];
        dec_cnt <= (dec_cnt == LAST_DEC) ? '0 : dec_cnt + 1'b1;
      end
      // Operands are registered one cycle ahead so they line up with the issue state;
      // the first operand is the sample being popped on the same edge.
      mac_valid_q <= (state_n == S_ISSUE);
      mac_clear_q <= (state == S_LOAD) && (state_n == S_ISSUE);
      if (state_n == S_ISSUE)
        mac_x_q <= (state == S_ISSUE) ? hist[tap_cnt + 1'b1] : bus.in_dout;
      else
        mac_x_q <= '0;
      if (state == S_ISSUE) tap_cnt <= (tap_cnt == LAST_TAP) ? '0 : tap_cnt + 1'b1;
      wait_cnt <= ((state == S_WAIT) && (wait_cnt != LAST_WAIT)) ? wait_cnt + 1'b1 : '0;
      if ((state == S_WAIT) && (wait_cnt == LAST_WAIT)) result_q <= bus.mac_acc;
    end
  end

  assign bus.in_rd_en  = pop;
  assign bus.out_wr_en = push;
  assign bus.mac_valid = mac_valid_q;
  assign bus.mac_clear = mac_clear_q;
  assign bus.mac_x     = mac_x_q;
  assign bus.mac_tap   = tap_cnt;
  assign bus.out_din   = result_q;
endmodule

// File: doc/fir_mac_ctrl.md
Name: fir_mac_ctrl

Overview:
- Sequencer for the shared multiply-accumulate datapath of the FIR stages in the demod chain.
- Pops quantized samples from an input FIFO and keeps the NUM_TAPS-deep sample history.
- Issues one (sample, tap-index) pair per cycle to an external MAC and coefficient ROM, waits for the accumulated result, and pushes it to an output FIFO.
- Supports decimation: one output per DECIMATION input samples.

Parameters:
DATA_SIZE, 32, width of samples, accumulator and output words (quantized, QUANT_VAL scaling).
NUM_TAPS, 32, filter length; also depth of the sample history.
DECIMATION, 1, input samples consumed per output produced (>=1).
MAC_LATENCY, 1, cycles from the last issue to mac_acc holding the final sum (>=1).

Ports:
clock  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
in_empty  in  1  input FIFO empty (show-ahead FIFO).
in_dout  in  DATA_SIZE  input FIFO head word, signed; valid when !in_empty.
in_rd_en  out  1  pops in_dout this cycle.
mac_valid  out  1  MAC operand pair valid this cycle.
mac_clear  out  1  with mac_valid: accumulator loads the product instead of adding.
mac_x  out  DATA_SIZE  sample operand, signed.
mac_tap  out  $clog2(NUM_TAPS)  tap index; drives coefficient ROM address, ROM output goes straight to MAC.
mac_acc  in  DATA_SIZE  MAC accumulator (per-product dequantization done inside MAC).
out_full  in  1  output FIFO full.
out_wr_en  out  1  pushes out_din.
out_din  out  DATA_SIZE  filter output word.

Behaviour:
- Reset (async): state=S_LOAD, history all 0, counters 0, result register 0. in_rd_en, mac_valid, mac_clear, out_wr_en = 0. mac_x, mac_tap, out_din = 0.
- All outputs are registered, except in_rd_en and out_wr_en, which are combinational from state and FIFO flags.
- History: hist[0] is the newest sample. On each pop: hist[k] <= hist[k-1], hist[0] <= in_dout.
- S_LOAD:
  - in_rd_en = !in_empty.
  - On each pop, dec_cnt increments.
  - The pop with dec_cnt == DECIMATION-1 clears dec_cnt and moves to S_ISSUE with tap_cnt = 0.
  - With in_empty, the block stalls indefinitely with no other activity.
- S_ISSUE: one issue per cycle for tap_cnt = 0..NUM_TAPS-1.
  - mac_valid = 1, mac_x = hist[tap_cnt], mac_tap = tap_cnt.
  - mac_clear = 1 only when tap_cnt == 0.
  - in_rd_en = 0 throughout (history frozen).
  - After tap NUM_TAPS-1: go to S_WAIT with wait_cnt = 0.
  - Exactly NUM_TAPS consecutive issue cycles, no bubbles.
- S_WAIT:
  - mac_valid = 0.
  - mac_acc is captured into the result register exactly MAC_LATENCY cycles after the cycle the last tap was issued; then go to S_WRITE.
- S_WRITE:
  - out_din = result.
  - out_wr_en = !out_full.
  - When out_wr_en = 1, return to S_LOAD next cycle.
  - While out_full, hold result and wait, with no pops and no issues.
- Throughput: with input never empty and output never full, one output every DECIMATION + NUM_TAPS + MAC_LATENCY + 1 cycles.
- The first NUM_TAPS-1 outputs use the zero-initialized history (no warm-up suppression).
- Arithmetic: the block performs no arithmetic on data. mac_acc passes to out_din bit-exact, signed, no saturation.
- Counters:
  - tap_cnt wraps from NUM_TAPS-1 to 0 on leaving S_ISSUE.
  - dec_cnt wraps from DECIMATION-1 to 0.
  - With DECIMATION = 1, every pop triggers an issue burst.
- Simultaneous in_empty deassert and out_full deassert: irrelevant. Only one handshake is active per state.
- Reset mid-operation (any state): immediate return to reset values. The history is cleared, and a partially issued burst is abandoned with no out_wr_en.

Test Plan:
1. NUM_TAPS=4, DECIMATION=1; push 1,2,3 (quantized 1024,2048,3072) -> third burst issues (mac_x,mac_tap) = (3072,0),(2048,1),(1024,2),(0,3), with mac_clear on tap 0 only.
2. Behavioural MAC (latency 1, coeffs 1024,512,256,128, per-product >>10); push impulse 1024 then zeros -> out_din = 1024,512,256,128,0 in order.
3. DECIMATION=4, 8 input samples, no stalls -> exactly 2 outputs. in_rd_en high for 4 cycles before each burst; output spacing 4+4+1+1 = 10 cycles.
4. Hold out_full for 20 cycles at S_WRITE -> out_din stable, no in_rd_en or mac_valid. Release -> single out_wr_en, then resume popping.
5. in_empty toggled randomly while running a 64-sample random stream -> output sequence matches golden FIR model bit-exactly, with no extra or missing writes.
6. Assert reset during tap 2 of a burst -> outputs zero immediately, no write for that burst. After release, an impulse behaves as in test 2 (history cleared).
